// File: rtl/pbs_pkg.sv
// Shared types and constants for the Pokemon battle controller.
//   state_e : 4-bit encoded battle state, values 0..9 as exposed on state_id
//   MV_*    : move_op encodings supplied by the menu/input decoder
package pbs_pkg;

  typedef enum logic [3:0] {
    S_MENU       = 4'd0,
    S_P_ATTACK   = 4'd1,
    S_P_HEAL     = 4'd2,
    S_CATCH      = 4'd3,
    S_CATCH_FAIL = 4'd4,
    S_AI_ATTACK  = 4'd5,
    S_VICTORY    = 4'd6,
    S_LOSS       = 4'd7,
    S_CAUGHT     = 4'd8,
    S_DRAW       = 4'd9
  } state_e;

  localparam logic [1:0] MV_BATTLE = 2'b00;
  localparam logic [1:0] MV_HEAL   = 2'b01;
  localparam logic [1:0] MV_CATCH  = 2'b10;
  localparam logic [1:0] MV_RSVD   = 2'b11;

endpackage

// File: rtl/pbs_battle_ctrl_if.sv
// Bus between the menu/input decoder (master) and the battle controller (slave).
//   master drives : go, move_op, ai_dmg, p_dmg, catch_success
//   slave drives  : HP, budgets, turn count, state_id, event pulses, terminal flags
interface pbs_battle_ctrl_if #(
  parameter int unsigned HP_W       = 8,
  parameter int unsigned HEALS      = 3,
  parameter int unsigned CATCHES    = 3,
  parameter int unsigned TURN_LIMIT = 50
) ();

  localparam int unsigned HL_W = $clog2(HEALS + 1);
  localparam int unsigned CL_W = $clog2(CATCHES + 1);
  localparam int unsigned TC_W = $clog2(TURN_LIMIT + 1);

  logic            go;
  logic [1:0]      move_op;
  logic [HP_W-1:0] ai_dmg;
  logic [HP_W-1:0] p_dmg;
  logic            catch_success;

  logic [HP_W-1:0] p_hp;
  logic [HP_W-1:0] ai_hp;
  logic [HL_W-1:0] heals_left;
  logic [CL_W-1:0] catches_left;
  logic [TC_W-1:0] turn_count;
  logic [3:0]      state_id;
  logic            apply_ai_damage;
  logic            apply_p_damage;
  logic            p_heal;
  logic            catch;
  logic            catch_fail;
  logic            victory;
  logic            loss;
  logic            caught;
  logic            draw;
  logic            illegal_op;

  modport master (
    output go, move_op, ai_dmg, p_dmg, catch_success,
    input  p_hp, ai_hp, heals_left, catches_left, turn_count, state_id,
           apply_ai_damage, apply_p_damage, p_heal, catch, catch_fail,
           victory, loss, caught, draw, illegal_op
  );

  modport slave (
    input  go, move_op, ai_dmg, p_dmg, catch_success,
    output p_hp, ai_hp, heals_left, catches_left, turn_count, state_id,
           apply_ai_damage, apply_p_damage, p_heal, catch, catch_fail,
           victory, loss, caught, draw, illegal_op
  );

endinterface

// File: rtl/pbs_hp_reg.sv
// Saturating HP register: subtract clamps at 0, add clamps at MAX.
//   clk, reset_n       : clock, synchronous active-low reset (loads INIT)
//   sub_en, sub_val    : apply damage this cycle (takes priority over add)
//   add_en, add_val    : apply healing this cycle
//   hp                 : current HP
//   zero_next          : combinational, pending update leaves HP at 0
module pbs_hp_reg #(
  parameter int unsigned HP_W = 8,
  parameter int unsigned INIT = 100,
  parameter int unsigned MAX  = 100
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            sub_en,
  input  logic [HP_W-1:0] sub_val,
  input  logic            add_en,
  input  logic [HP_W-1:0] add_val,
  output logic [HP_W-1:0] hp,
  output logic            zero_next
);

  localparam int unsigned SUM_W = HP_W + 1;

  logic [HP_W-1:0]  hp_nxt;
  logic [SUM_W-1:0] sum;

  // Next-value computation; sum carries one extra bit so overflow cannot wrap
  always_comb begin
    hp_nxt = hp;
    sum    = {1'b0, hp} + {1'b0, add_val};
    if (sub_en) begin
      hp_nxt = (sub_val >= hp) ? '0 : hp - sub_val;
    end else if (add_en) begin
      hp_nxt = (sum > SUM_W'(MAX)) ? HP_W'(MAX) : sum[HP_W-1:0];
    end
  end

  assign zero_next = (hp_nxt == '0);

  always_ff @(posedge clk) begin
    if (!reset_n) hp <= HP_W'(INIT);
    else          hp <= hp_nxt;
  end

endmodule

// File: rtl/pbs_battle_ctrl.sv
// Battle controller: sequences player action -> AI counter-attack -> menu,
// owns both HP registers, heal/catch budgets and the turn counter, and
// detects victory, loss, capture and draw.
//   clk, reset_n : clock, synchronous active-low reset
//   bus          : slave side of pbs_battle_ctrl_if (inputs from the menu
//                  decoder, HP/state/event outputs to the display path)
module pbs_battle_ctrl
  import pbs_pkg::*;
#(
  parameter int unsigned HP_W       = 8,
  parameter int unsigned P_MAX_HP   = 100,
  parameter int unsigned AI_MAX_HP  = 100,
  parameter int unsigned HEAL_AMT   = 30,
  parameter int unsigned HEALS      = 3,
  parameter int unsigned CATCHES    = 3,
  parameter int unsigned TURN_LIMIT = 50
) (
  input logic                clk,
  input logic                reset_n,
  pbs_battle_ctrl_if.slave   bus
);

  localparam int unsigned HL_W = $clog2(HEALS + 1);
  localparam int unsigned CL_W = $clog2(CATCHES + 1);
  localparam int unsigned TC_W = $clog2(TURN_LIMIT + 1);

  state_e          state;
  state_e          state_nxt;
  logic [HL_W-1:0] heals_left;
  logic [CL_W-1:0] catches_left;
  logic [TC_W-1:0] turn_count;
  logic [HP_W-1:0] p_hp;
  logic [HP_W-1:0] ai_hp;

  logic ai_sub_en;
  logic p_sub_en;
  logic p_add_en;
  logic heal_dec;
  logic catch_dec;
  logic turn_inc;
  logic illegal_nxt;
  logic ai_zero_next;
  logic p_zero_next;

  pbs_hp_reg #(.HP_W(HP_W), .INIT(P_MAX_HP), .MAX(P_MAX_HP)) u_p_hp (
    .clk       (clk),
    .reset_n   (reset_n),
    .sub_en    (p_sub_en),
    .sub_val   (bus.p_dmg),
    .add_en    (p_add_en),
    .add_val   (HP_W'(HEAL_AMT)),
    .hp        (p_hp),
    .zero_next (p_zero_next)
  );

  pbs_hp_reg #(.HP_W(HP_W), .INIT(AI_MAX_HP), .MAX(AI_MAX_HP)) u_ai_hp (
    .clk       (clk),
    .reset_n   (reset_n),
    .sub_en    (ai_sub_en),
    .sub_val   (bus.ai_dmg),
    .add_en    (1'b0),
    .add_val   ('0),
    .hp        (ai_hp),
    .zero_next (ai_zero_next)
  );

  // Next-state and update-enable decode
  always_comb begin
    state_nxt   = state;
    ai_sub_en   = 1'b0;
    p_sub_en    = 1'b0;
    p_add_en    = 1'b0;
    heal_dec    = 1'b0;
    catch_dec   = 1'b0;
    turn_inc    = 1'b0;
    illegal_nxt = 1'b0;
    case (state)
      S_MENU: begin
        if (bus.go) begin
          case (bus.move_op)
            MV_BATTLE: state_nxt = S_P_ATTACK;
            MV_HEAL: begin
              if (heals_left != '0) state_nxt = S_P_HEAL;
              else                  illegal_nxt = 1'b1;
            end
            MV_CATCH: begin
              if (catches_left != '0) state_nxt = S_CATCH;
              else                    illegal_nxt = 1'b1;
            end
            MV_RSVD:  illegal_nxt = 1'b1;
            default:  illegal_nxt = 1'b1;
          endcase
        end
      end
      S_P_ATTACK: begin
        ai_sub_en = 1'b1;
        // A knockout ends the battle before the AI gets to respond
        state_nxt = ai_zero_next ? S_VICTORY : S_AI_ATTACK;
      end
      S_P_HEAL: begin
        p_add_en  = 1'b1;
        heal_dec  = 1'b1;
        state_nxt = S_AI_ATTACK;
      end
      S_CATCH: begin
        catch_dec = 1'b1;
        state_nxt = bus.catch_success ? S_CAUGHT : S_CATCH_FAIL;
      end
      S_CATCH_FAIL: state_nxt = S_AI_ATTACK;
      S_AI_ATTACK: begin
        p_sub_en = 1'b1;
        // Loss wins over the turn limit; a lost turn is not counted
        if (p_zero_next) begin
          state_nxt = S_LOSS;
        end else begin
          turn_inc  = 1'b1;
          state_nxt = (turn_count == TC_W'(TURN_LIMIT - 1)) ? S_DRAW : S_MENU;
        end
      end
      S_VICTORY, S_LOSS, S_CAUGHT, S_DRAW: state_nxt = state;
      default: state_nxt = S_MENU;
    endcase
  end

  // State, budgets, turn counter
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state        <= S_MENU;
      heals_left   <= HL_W'(HEALS);
      catches_left <= CL_W'(CATCHES);
      turn_count   <= '0;
    end else begin
      state <= state_nxt;
      if (heal_dec)  heals_left   <= heals_left - HL_W'(1);
      if (catch_dec) catches_left <= catches_left - CL_W'(1);
      if (turn_inc)  turn_count   <= turn_count + TC_W'(1);
    end
  end

  // Event pulses and flags, registered from the next state so they track state
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      bus.apply_ai_damage <= 1'b0;
      bus.apply_p_damage  <= 1'b0;
      bus.p_heal          <= 1'b0;
      bus.catch           <= 1'b0;
      bus.catch_fail      <= 1'b0;
      bus.victory         <= 1'b0;
      bus.loss            <= 1'b0;
      bus.caught          <= 1'b0;
      bus.draw            <= 1'b0;
      bus.illegal_op      <= 1'b0;
    end else begin
      bus.apply_ai_damage <= (state_nxt == S_P_ATTACK);
      bus.apply_p_damage  <= (state_nxt == S_AI_ATTACK);
      bus.p_heal          <= (state_nxt == S_P_HEAL);
      bus.catch           <= (state_nxt == S_CATCH);
      bus.catch_fail      <= (state_nxt == S_CATCH_FAIL);
      bus.victory         <= (state_nxt == S_VICTORY);
      bus.loss            <= (state_nxt == S_LOSS);
      bus.caught          <= (state_nxt == S_CAUGHT);
      bus.draw            <= (state_nxt == S_DRAW);
      bus.illegal_op      <= illegal_nxt;
    end
  end

  assign bus.p_hp         = p_hp;
  assign bus.ai_hp        = ai_hp;
  assign bus.heals_left   = heals_left;
  assign bus.catches_left = catches_left;
  assign bus.turn_count   = turn_count;
  assign bus.state_id     = state;

endmodule

// File: tb/tb_pbs_battle_ctrl.sv
// Directed bench for pbs_battle_ctrl: dut_a uses default parameters,
// dut_b uses TURN_LIMIT=2 for the draw/loss-ordering scenarios.
module tb_pbs_battle_ctrl;

  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_err;

  pbs_battle_ctrl_if #(.HP_W(8), .HEALS(3), .CATCHES(3), .TURN_LIMIT(50)) bus_a ();
  pbs_battle_ctrl_if #(.HP_W(8), .HEALS(3), .CATCHES(3), .TURN_LIMIT(2))  bus_b ();

  pbs_battle_ctrl #(.HP_W(8), .P_MAX_HP(100), .AI_MAX_HP(100), .HEAL_AMT(30),
                    .HEALS(3), .CATCHES(3), .TURN_LIMIT(50)) dut_a (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_a)
  );

  pbs_battle_ctrl #(.HP_W(8), .P_MAX_HP(100), .AI_MAX_HP(100), .HEAL_AMT(30),
                    .HEALS(3), .CATCHES(3), .TURN_LIMIT(2)) dut_b (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  // Pulse go on dut_a for one cycle; returns at the negedge after it was sampled
  task automatic go_a(input logic [1:0] op, input logic [7:0] ad, input logic [7:0] pd,
                      input logic cs);
    bus_a.move_op = op; bus_a.ai_dmg = ad; bus_a.p_dmg = pd; bus_a.catch_success = cs;
    bus_a.go = 1'b1;
    step();
    bus_a.go = 1'b0;
  endtask

  task automatic go_b(input logic [1:0] op, input logic [7:0] ad, input logic [7:0] pd);
    bus_b.move_op = op; bus_b.ai_dmg = ad; bus_b.p_dmg = pd; bus_b.catch_success = 1'b0;
    bus_b.go = 1'b1;
    step();
    bus_b.go = 1'b0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step();
    step();
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if ({bus_a.p_hp, bus_a.ai_hp} !== {8'd100, 8'd100}) begin
      n_err++; $display("FAIL reset_hp: got %0d/%0d want 100/100", bus_a.p_hp, bus_a.ai_hp);
    end
    n_cmp++;
    if ({bus_a.heals_left, bus_a.catches_left, bus_a.turn_count, bus_a.state_id} !==
        {2'd3, 2'd3, 6'd0, 4'd0}) begin
      n_err++; $display("FAIL reset_cnt: got h%0d c%0d t%0d s%0d want h3 c3 t0 s0",
                        bus_a.heals_left, bus_a.catches_left, bus_a.turn_count, bus_a.state_id);
    end
    n_cmp++;
    if ({bus_a.apply_ai_damage, bus_a.apply_p_damage, bus_a.p_heal, bus_a.catch,
         bus_a.catch_fail, bus_a.victory, bus_a.loss, bus_a.caught, bus_a.draw,
         bus_a.illegal_op} !== 10'b0) begin
      n_err++; $display("FAIL reset_flags: some flag set, want all 0");
    end
    n_cmp++;
    if ({bus_b.p_hp, bus_b.ai_hp, bus_b.turn_count, bus_b.state_id} !==
        {8'd100, 8'd100, 2'd0, 4'd0}) begin
      n_err++; $display("FAIL reset_b: got p%0d a%0d t%0d s%0d want p100 a100 t0 s0",
                        bus_b.p_hp, bus_b.ai_hp, bus_b.turn_count, bus_b.state_id);
    end
  endtask

  task automatic test_battle();
    go_a(2'b00, 8'd40, 8'd15, 1'b0);
    n_cmp++;
    if ({bus_a.state_id, bus_a.apply_ai_damage, bus_a.apply_p_damage} !== {4'd1, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL battle_patk: got s%0d aad%0b apd%0b want s1 aad1 apd0",
                        bus_a.state_id, bus_a.apply_ai_damage, bus_a.apply_p_damage);
    end
    step();
    n_cmp++;
    if ({bus_a.state_id, bus_a.apply_ai_damage, bus_a.apply_p_damage, bus_a.ai_hp} !==
        {4'd5, 1'b0, 1'b1, 8'd60}) begin
      n_err++; $display("FAIL battle_aiatk: got s%0d aad%0b apd%0b ai%0d want s5 aad0 apd1 ai60",
                        bus_a.state_id, bus_a.apply_ai_damage, bus_a.apply_p_damage, bus_a.ai_hp);
    end
    step();
    n_cmp++;
    if ({bus_a.state_id, bus_a.apply_p_damage, bus_a.p_hp, bus_a.ai_hp, bus_a.turn_count} !==
        {4'd0, 1'b0, 8'd85, 8'd60, 6'd1}) begin
      n_err++; $display("FAIL battle_menu: got s%0d apd%0b p%0d ai%0d t%0d want s0 apd0 p85 ai60 t1",
                        bus_a.state_id, bus_a.apply_p_damage, bus_a.p_hp, bus_a.ai_hp, bus_a.turn_count);
    end
  endtask

  task automatic test_heal();
    go_a(2'b01, 8'd0, 8'd0, 1'b0);
    n_cmp++;
    if ({bus_a.state_id, bus_a.p_heal} !== {4'd2, 1'b1}) begin
      n_err++; $display("FAIL heal_state: got s%0d ph%0b want s2 ph1", bus_a.state_id, bus_a.p_heal);
    end
    step();
    n_cmp++;
    if ({bus_a.p_hp, bus_a.heals_left, bus_a.state_id} !== {8'd100, 2'd2, 4'd5}) begin
      n_err++; $display("FAIL heal_sat: got p%0d h%0d s%0d want p100 h2 s5",
                        bus_a.p_hp, bus_a.heals_left, bus_a.state_id);
    end
    step();
    for (int i = 0; i < 2; i++) begin
      go_a(2'b01, 8'd0, 8'd0, 1'b0);
      step();
      step();
    end
    n_cmp++;
    if ({bus_a.heals_left, bus_a.turn_count, bus_a.state_id} !== {2'd0, 6'd4, 4'd0}) begin
      n_err++; $display("FAIL heal_budget: got h%0d t%0d s%0d want h0 t4 s0",
                        bus_a.heals_left, bus_a.turn_count, bus_a.state_id);
    end
    go_a(2'b01, 8'd0, 8'd0, 1'b0);
    n_cmp++;
    if ({bus_a.illegal_op, bus_a.state_id, bus_a.p_hp, bus_a.heals_left, bus_a.turn_count} !==
        {1'b1, 4'd0, 8'd100, 2'd0, 6'd4}) begin
      n_err++; $display("FAIL heal_exhaust: got ill%0b s%0d p%0d h%0d t%0d want ill1 s0 p100 h0 t4",
                        bus_a.illegal_op, bus_a.state_id, bus_a.p_hp, bus_a.heals_left, bus_a.turn_count);
    end
    step();
    n_cmp++;
    if ({bus_a.illegal_op, bus_a.state_id} !== {1'b0, 4'd0}) begin
      n_err++; $display("FAIL illegal_pulse: got ill%0b s%0d want ill0 s0", bus_a.illegal_op, bus_a.state_id);
    end
    go_a(2'b11, 8'd50, 8'd50, 1'b0);
    n_cmp++;
    if ({bus_a.illegal_op, bus_a.state_id, bus_a.p_hp, bus_a.ai_hp, bus_a.catches_left} !==
        {1'b1, 4'd0, 8'd100, 8'd60, 2'd3}) begin
      n_err++; $display("FAIL op_rsvd: got ill%0b s%0d p%0d ai%0d c%0d want ill1 s0 p100 ai60 c3",
                        bus_a.illegal_op, bus_a.state_id, bus_a.p_hp, bus_a.ai_hp, bus_a.catches_left);
    end
    step();
  endtask

  task automatic test_catch();
    go_a(2'b10, 8'd0, 8'd10, 1'b0);
    n_cmp++;
    if ({bus_a.state_id, bus_a.catch} !== {4'd3, 1'b1}) begin
      n_err++; $display("FAIL catch_state: got s%0d c%0b want s3 c1", bus_a.state_id, bus_a.catch);
    end
    step();
    n_cmp++;
    if ({bus_a.state_id, bus_a.catch_fail, bus_a.catches_left} !== {4'd4, 1'b1, 2'd2}) begin
      n_err++; $display("FAIL catch_fail: got s%0d cf%0b c%0d want s4 cf1 c2",
                        bus_a.state_id, bus_a.catch_fail, bus_a.catches_left);
    end
    step();
    n_cmp++;
    if ({bus_a.state_id, bus_a.apply_p_damage, bus_a.catch_fail} !== {4'd5, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL catch_aiatk: got s%0d apd%0b cf%0b want s5 apd1 cf0",
                        bus_a.state_id, bus_a.apply_p_damage, bus_a.catch_fail);
    end
    step();
    n_cmp++;
    if ({bus_a.state_id, bus_a.p_hp, bus_a.turn_count} !== {4'd0, 8'd90, 6'd5}) begin
      n_err++; $display("FAIL catch_turn: got s%0d p%0d t%0d want s0 p90 t5",
                        bus_a.state_id, bus_a.p_hp, bus_a.turn_count);
    end
    go_a(2'b10, 8'd0, 8'd10, 1'b1);
    step();
    n_cmp++;
    if ({bus_a.state_id, bus_a.caught, bus_a.catches_left, bus_a.p_hp} !== {4'd8, 1'b1, 2'd1, 8'd90}) begin
      n_err++; $display("FAIL caught: got s%0d cg%0b c%0d p%0d want s8 cg1 c1 p90",
                        bus_a.state_id, bus_a.caught, bus_a.catches_left, bus_a.p_hp);
    end
    go_a(2'b11, 8'd50, 8'd50, 1'b0);
    step();
    n_cmp++;
    if ({bus_a.state_id, bus_a.caught, bus_a.illegal_op, bus_a.ai_hp, bus_a.turn_count} !==
        {4'd8, 1'b1, 1'b0, 8'd60, 6'd5}) begin
      n_err++; $display("FAIL caught_absorb: got s%0d cg%0b ill%0b ai%0d t%0d want s8 cg1 ill0 ai60 t5",
                        bus_a.state_id, bus_a.caught, bus_a.illegal_op, bus_a.ai_hp, bus_a.turn_count);
    end
  endtask

  task automatic test_victory();
    logic saw_apd;
    do_reset();
    saw_apd = 1'b0;
    go_a(2'b00, 8'd200, 8'd15, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      saw_apd = saw_apd | bus_a.apply_p_damage;
    end
    n_cmp++;
    if ({bus_a.state_id, bus_a.victory, bus_a.ai_hp, bus_a.p_hp, saw_apd} !==
        {4'd6, 1'b1, 8'd0, 8'd100, 1'b0}) begin
      n_err++; $display("FAIL victory: got s%0d v%0b ai%0d p%0d apd_seen%0b want s6 v1 ai0 p100 apd_seen0",
                        bus_a.state_id, bus_a.victory, bus_a.ai_hp, bus_a.p_hp, saw_apd);
    end
    go_a(2'b00, 8'd5, 8'd5, 1'b0);
    step();
    n_cmp++;
    if ({bus_a.state_id, bus_a.victory, bus_a.illegal_op, bus_a.p_hp, bus_a.turn_count} !==
        {4'd6, 1'b1, 1'b0, 8'd100, 6'd0}) begin
      n_err++; $display("FAIL victory_absorb: got s%0d v%0b ill%0b p%0d t%0d want s6 v1 ill0 p100 t0",
                        bus_a.state_id, bus_a.victory, bus_a.illegal_op, bus_a.p_hp, bus_a.turn_count);
    end
  endtask

  task automatic test_draw();
    do_reset();
    go_b(2'b00, 8'd5, 8'd5);
    step();
    step();
    n_cmp++;
    if ({bus_b.state_id, bus_b.turn_count, bus_b.draw} !== {4'd0, 2'd1, 1'b0}) begin
      n_err++; $display("FAIL draw_turn1: got s%0d t%0d d%0b want s0 t1 d0",
                        bus_b.state_id, bus_b.turn_count, bus_b.draw);
    end
    go_b(2'b00, 8'd5, 8'd5);
    step();
    step();
    n_cmp++;
    if ({bus_b.state_id, bus_b.draw, bus_b.loss, bus_b.turn_count, bus_b.p_hp, bus_b.ai_hp} !==
        {4'd9, 1'b1, 1'b0, 2'd2, 8'd90, 8'd90}) begin
      n_err++; $display("FAIL draw: got s%0d d%0b l%0b t%0d p%0d ai%0d want s9 d1 l0 t2 p90 ai90",
                        bus_b.state_id, bus_b.draw, bus_b.loss, bus_b.turn_count, bus_b.p_hp, bus_b.ai_hp);
    end
  endtask

  task automatic test_loss_over_draw();
    do_reset();
    go_b(2'b00, 8'd5, 8'd5);
    step();
    step();
    go_b(2'b00, 8'd5, 8'd95);
    step();
    step();
    n_cmp++;
    if ({bus_b.state_id, bus_b.loss, bus_b.draw, bus_b.p_hp, bus_b.turn_count} !==
        {4'd7, 1'b1, 1'b0, 8'd0, 2'd1}) begin
      n_err++; $display("FAIL loss_prio: got s%0d l%0b d%0b p%0d t%0d want s7 l1 d0 p0 t1",
                        bus_b.state_id, bus_b.loss, bus_b.draw, bus_b.p_hp, bus_b.turn_count);
    end
  endtask

  task automatic test_reset_mid_turn();
    do_reset();
    go_a(2'b00, 8'd40, 8'd15, 1'b0);
    step();
    n_cmp++;
    if ({bus_a.state_id, bus_a.ai_hp} !== {4'd5, 8'd60}) begin
      n_err++; $display("FAIL mid_setup: got s%0d ai%0d want s5 ai60", bus_a.state_id, bus_a.ai_hp);
    end
    reset_n = 1'b0;
    step();
    n_cmp++;
    if ({bus_a.state_id, bus_a.p_hp, bus_a.ai_hp, bus_a.turn_count, bus_a.apply_p_damage,
         bus_a.heals_left, bus_a.catches_left} !==
        {4'd0, 8'd100, 8'd100, 6'd0, 1'b0, 2'd3, 2'd3}) begin
      n_err++; $display("FAIL mid_reset: got s%0d p%0d ai%0d t%0d apd%0b want s0 p100 ai100 t0 apd0",
                        bus_a.state_id, bus_a.p_hp, bus_a.ai_hp, bus_a.turn_count, bus_a.apply_p_damage);
    end
    reset_n = 1'b1;
    step();
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset_n = 1'b0;
    bus_a.go = 1'b0; bus_a.move_op = 2'b00; bus_a.ai_dmg = '0; bus_a.p_dmg = '0;
    bus_a.catch_success = 1'b0;
    bus_b.go = 1'b0; bus_b.move_op = 2'b00; bus_b.ai_dmg = '0; bus_b.p_dmg = '0;
    bus_b.catch_success = 1'b0;
    step();
    test_reset();
    test_battle();
    test_heal();
    test_catch();
    test_victory();
    test_draw();
    test_loss_over_draw();
    test_reset_mid_turn();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
